fg_period_sequencer: RTL and testbench
======================================

// Module: fg_period_sequencer
// PURPOSE
//  Sequences one waveform generator channel. Generates the tick enable (clk_en) and the
//  period counter register (CR) that drive the generator. Double-buffers shape parameters
//  from a valid/ready config port so updates take effect only at a period boundary (CR==0).
//  Supports start/stop, a clock prescaler and burst mode (N periods, then stop).
// PARAMETERS
//  COUNTER_BITWIDTH    32  width of CR, period and ON counters
//  WAVEFORM_BITWIDTH   16  width of k_rise, k_fall and amplitude
//  PRESCALER_BITWIDTH  16  width of prescaler divide value
//  BURST_BITWIDTH       8  width of burst period count
// PORTS
//  clk_i          in   1     clock, single domain
//  rst_i          in   1     synchronous reset, active-high
//  start_i        in   1     start request (pulse)
//  stop_i         in   1     graceful stop request (pulse)
//  prescaler_i    in   PB    tick every prescaler_i+1 clocks; latched at start
//  burst_i        in   BB    periods per run, 0 = continuous; latched at start
//  cfg_valid_i    in   1     config word valid
//  cfg_ready_o    out  1     config buffer free (= !pending_valid, registered)
//  cfg_period_i   in   CB    last CR value of a period (period = cfg_period_i+1 ticks)
//  cfg_on_i       in   CB    ON counter value
//  cfg_k_rise_i   in   WB    rise slope
//  cfg_k_fall_i   in   WB    fall slope
//  cfg_amp_i      in   WB    amplitude
//  clk_en_o       out  1     generator tick enable, one-cycle pulses
//  cr_o           out  CB    counter register, stable while clk_en_o=1
//  counter_o, on_counter_o, k_rise_o, k_fall_o, amplitude_o  out  CB/CB/WB/WB/WB  committed params
//  period_start_o out  1     1 on the tick where cr_o==0
//  busy_o         out  1     state != IDLE
//  done_o         out  1     one-cycle pulse on entry to IDLE from RUN/DRAIN
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state IDLE; all outputs 0 except cfg_ready_o=1; pending buffer
//   and prescaler/burst counters cleared. Reset mid-run aborts immediately with no done_o.
//  Config: accepted when cfg_valid_i & cfg_ready_o and stored in pending. Commit copies
//   pending to the *_o params and clears pending_valid. Commit occurs (a) the cycle after
//   acceptance while IDLE, (b) on the edge where cr_o wraps to 0, (c) on the start edge.
//   cfg_ready_o is low while pending is held; no bypass. Values are passed through unchecked.
//  FSM: IDLE -start_i-> RUN; RUN -stop_i-> DRAIN; RUN -(burst done)-> IDLE;
//   DRAIN -(tick with cr_o==counter_o)-> IDLE. If start_i and stop_i are high in the same
//   cycle, stop wins (start is ignored in IDLE). start_i in RUN/DRAIN and stop_i in IDLE
//   are ignored.
//  Start at edge t: from t+1 RUN, cr_o=0, clk_en_o=1 (immediate first tick). Then
//   clk_en_o=1 every P+1 cycles (P = latched prescaler); P=0 -> clk_en_o held 1.
//  CR: on each edge with clk_en_o=1: cr_o <= (cr_o==counter_o) ? 0 : cr_o+1.
//   counter_o=0 -> cr_o stays 0 and every tick is a period start.
//  Burst: periods_done increments at each wrap. When burst_i!=0 and the wrap completes
//   period burst_i: go to IDLE, no further clk_en_o, and done_o pulses.
//  IDLE: clk_en_o=0, cr_o=0, params hold their committed values.
// TESTING
//  1 reset, cfg{period=3,on=2,kr=4,kf=4,amp=8}, start, P=0 -> clk_en_o constant 1;
//    cr_o 0,1,2,3,0,...; period_start_o on each cr_o==0.
//  2 P=2 -> clk_en_o 1 every 3rd cycle, first in cycle after start; cr_o changes only
//    after a tick.
//  3 mid-period cfg amp=5 -> cfg_ready_o=0; amplitude_o stays 8 until wrap edge, then 5;
//    cfg_ready_o=1 the next cycle.
//  4 burst=2, period=1 -> exactly 4 ticks, then IDLE; done_o pulses once; busy_o falls.
//  5 stop at cr_o=1 (period=3) -> ticks continue to cr_o=3, then IDLE with cr_o=0;
//    start+stop in the same cycle while IDLE -> stays IDLE.
//  6 rst_i at cr_o=2 -> next cycle all outputs 0, cfg_ready_o=1, no done_o.

Source files
------------

// File: rtl/fg_period_sequencer.sv
// Waveform generator channel sequencer: tick enable, period counter,
// double-buffered shape parameters, prescaler and burst control.
module fg_period_sequencer #(
  parameter int COUNTER_BITWIDTH   = 32,
  parameter int WAVEFORM_BITWIDTH  = 16,
  parameter int PRESCALER_BITWIDTH = 16,
  parameter int BURST_BITWIDTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  input  logic [BURST_BITWIDTH-1:0]     burst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_period_i,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_on_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_amp_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   cr_o,
  output logic [COUNTER_BITWIDTH-1:0]   counter_o,
  output logic [COUNTER_BITWIDTH-1:0]   on_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  amplitude_o,
  output logic                          period_start_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int CB = COUNTER_BITWIDTH;
  localparam int WB = WAVEFORM_BITWIDTH;
  localparam int PB = PRESCALER_BITWIDTH;
  localparam int BB = BURST_BITWIDTH;

  localparam logic [CB-1:0] CR_ONE = CB'(1);
  localparam logic [PB-1:0] PS_ONE = PB'(1);
  localparam logic [BB-1:0] BR_ONE = BB'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CB-1:0] cr_q, cr_d;
  logic [CB-1:0] counter_q, counter_d;
  logic [CB-1:0] on_q, on_d;
  logic [WB-1:0] k_rise_q, k_rise_d;
  logic [WB-1:0] k_fall_q, k_fall_d;
  logic [WB-1:0] amp_q, amp_d;

  logic [CB-1:0] pend_period_q, pend_period_d;
  logic [CB-1:0] pend_on_q, pend_on_d;
  logic [WB-1:0] pend_k_rise_q, pend_k_rise_d;
  logic [WB-1:0] pend_k_fall_q, pend_k_fall_d;
  logic [WB-1:0] pend_amp_q, pend_amp_d;
  logic          pend_valid_q, pend_valid_d;

  logic          cfg_ready_q, cfg_ready_d;
  logic          clk_en_q, clk_en_d;
  logic          ps_q, ps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PB-1:0] psc_q, psc_d;
  logic [PB-1:0] psc_cnt_q, psc_cnt_d;
  logic [BB-1:0] burst_q, burst_d;
  logic [BB-1:0] periods_q, periods_d;

  logic accept;
  logic start_go;
  logic wrap;
  logic burst_end;
  logic commit;

  always_comb begin
    state_d       = state_q;
    cr_d          = cr_q;
    counter_d     = counter_q;
    on_d          = on_q;
    k_rise_d      = k_rise_q;
    k_fall_d      = k_fall_q;
    amp_d         = amp_q;
    pend_period_d = pend_period_q;
    pend_on_d     = pend_on_q;
    pend_k_rise_d = pend_k_rise_q;
    pend_k_fall_d = pend_k_fall_q;
    pend_amp_d    = pend_amp_q;
    pend_valid_d  = pend_valid_q;
    clk_en_d      = clk_en_q;
    done_d        = 1'b0;
    psc_d         = psc_q;
    psc_cnt_d     = psc_cnt_q;
    burst_d       = burst_q;
    periods_d     = periods_q;

    accept    = cfg_valid_i & cfg_ready_q;
    start_go  = (state_q == IDLE) & start_i & ~stop_i;
    wrap      = clk_en_q & (cr_q == counter_q);
    burst_end = wrap & (burst_q != '0)
              & ((periods_q + BR_ONE) == burst_q);
    // Idle covers both the post-accept commit and the start edge.
    commit    = pend_valid_q & ((state_q == IDLE) | wrap);

    if (accept) begin
      pend_period_d = cfg_period_i;
      pend_on_d     = cfg_on_i;
      pend_k_rise_d = cfg_k_rise_i;
      pend_k_fall_d = cfg_k_fall_i;
      pend_amp_d    = cfg_amp_i;
      pend_valid_d  = 1'b1;
    end

    if (commit) begin
      counter_d    = pend_period_q;
      on_d         = pend_on_q;
      k_rise_d     = pend_k_rise_q;
      k_fall_d     = pend_k_fall_q;
      amp_d        = pend_amp_q;
      pend_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        clk_en_d = 1'b0;
        cr_d     = '0;
        if (start_go) begin
          state_d   = RUN;
          clk_en_d  = 1'b1;
          psc_d     = prescaler_i;
          psc_cnt_d = '0;
          burst_d   = burst_i;
          periods_d = '0;
        end
      end
      RUN, DRAIN: begin
        if (clk_en_q) begin
          cr_d = wrap ? '0 : cr_q + CR_ONE;
        end
        if (wrap) begin
          periods_d = periods_q + BR_ONE;
        end
        if (psc_cnt_q == psc_q) begin
          clk_en_d  = 1'b1;
          psc_cnt_d = '0;
        end else begin
          clk_en_d  = 1'b0;
          psc_cnt_d = psc_cnt_q + PS_ONE;
        end
        if (burst_end | ((state_q == DRAIN) & wrap)) begin
          state_d  = IDLE;
          clk_en_d = 1'b0;
          cr_d     = '0;
          done_d   = 1'b1;
        end else if ((state_q == RUN) & stop_i) begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d  = IDLE;
        clk_en_d = 1'b0;
        cr_d     = '0;
      end
    endcase

    cfg_ready_d = ~pend_valid_d;
    ps_d        = clk_en_d & (cr_d == '0);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cr_q          <= '0;
      counter_q     <= '0;
      on_q          <= '0;
      k_rise_q      <= '0;
      k_fall_q      <= '0;
      amp_q         <= '0;
      pend_period_q <= '0;
      pend_on_q     <= '0;
      pend_k_rise_q <= '0;
      pend_k_fall_q <= '0;
      pend_amp_q    <= '0;
      pend_valid_q  <= 1'b0;
      cfg_ready_q   <= 1'b1;
      clk_en_q      <= 1'b0;
      ps_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      psc_q         <= '0;
      psc_cnt_q     <= '0;
      burst_q       <= '0;
      periods_q     <= '0;
    end else begin
      state_q       <= state_d;
      cr_q          <= cr_d;
      counter_q     <= counter_d;
      on_q          <= on_d;
      k_rise_q      <= k_rise_d;
      k_fall_q      <= k_fall_d;
      amp_q         <= amp_d;
      pend_period_q <= pend_period_d;
      pend_on_q     <= pend_on_d;
      pend_k_rise_q <= pend_k_rise_d;
      pend_k_fall_q <= pend_k_fall_d;
      pend_amp_q    <= pend_amp_d;
      pend_valid_q  <= pend_valid_d;
      cfg_ready_q   <= cfg_ready_d;
      clk_en_q      <= clk_en_d;
      ps_q          <= ps_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      psc_q         <= psc_d;
      psc_cnt_q     <= psc_cnt_d;
      burst_q       <= burst_d;
      periods_q     <= periods_d;
    end
  end

  assign cfg_ready_o    = cfg_ready_q;
  assign clk_en_o       = clk_en_q;
  assign cr_o           = cr_q;
  assign counter_o      = counter_q;
  assign on_counter_o   = on_q;
  assign k_rise_o       = k_rise_q;
  assign k_fall_o       = k_fall_q;
  assign amplitude_o    = amp_q;
  assign period_start_o = ps_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_fg_period_sequencer.sv
// Directed bench for fg_period_sequencer: cycle table for run/stop/
// prescaler/reset, plus hand sequences for config buffering and bursts.
module tb_fg_period_sequencer;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stop_i;
  logic [15:0] prescaler_i;
  logic [7:0]  burst_i;
  logic        cfg_valid_i, cfg_ready_o;
  logic [31:0] cfg_period_i, cfg_on_i;
  logic [15:0] cfg_k_rise_i, cfg_k_fall_i, cfg_amp_i;
  logic        clk_en_o;
  logic [31:0] cr_o, counter_o, on_counter_o;
  logic [15:0] k_rise_o, k_fall_o, amplitude_o;
  logic        period_start_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fg_period_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .prescaler_i    (prescaler_i),
    .burst_i        (burst_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_period_i   (cfg_period_i),
    .cfg_on_i       (cfg_on_i),
    .cfg_k_rise_i   (cfg_k_rise_i),
    .cfg_k_fall_i   (cfg_k_fall_i),
    .cfg_amp_i      (cfg_amp_i),
    .clk_en_o       (clk_en_o),
    .cr_o           (cr_o),
    .counter_o      (counter_o),
    .on_counter_o   (on_counter_o),
    .k_rise_o       (k_rise_o),
    .k_fall_o       (k_fall_o),
    .amplitude_o    (amplitude_o),
    .period_start_o (period_start_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] presc;
    logic        en;
    logic [31:0] cr;
    logic        ps;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_cfg(input logic [31:0] per, input logic [15:0] amp);
    cfg_period_i = per;
    cfg_on_i     = 32'd2;
    cfg_k_rise_i = 16'd4;
    cfg_k_fall_i = 16'd4;
    cfg_amp_i    = amp;
    cfg_valid_i  = 1'b1;
    step();
    cfg_valid_i  = 1'b0;
  endtask

  initial begin
    int ticks;
    int dones;
    int pss;
    bit seen;

    tbl[0]  = '{0, 1, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 16'd0, 1, 1, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 16'd0, 1, 2, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 16'd0, 1, 3, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 16'd0, 1, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 1, 16'd0, 1, 2, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 16'd0, 1, 3, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 16'd0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 16'd0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 16'd0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 16'd2, 1, 0, 1, 1, 0};
    tbl[12] = '{0, 0, 0, 16'd2, 0, 1, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 16'd2, 0, 1, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 16'd2, 1, 1, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 16'd2, 0, 2, 0, 1, 0};
    tbl[16] = '{1, 0, 0, 16'd2, 0, 0, 0, 0, 0};

    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    prescaler_i = '0; burst_i = '0; cfg_valid_i = 1'b0;
    cfg_period_i = '0; cfg_on_i = '0;
    cfg_k_rise_i = '0; cfg_k_fall_i = '0; cfg_amp_i = '0;
    step();
    step();
    rst_i = 1'b0;

    chk("rst_clk_en", clk_en_o, 0);
    chk("rst_cr", cr_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_amp", amplitude_o, 0);

    put_cfg(32'd3, 16'd8);
    chk("idle_held_ready", cfg_ready_o, 0);
    chk("idle_held_amp", amplitude_o, 0);
    step();
    chk("idle_commit_amp", amplitude_o, 8);
    chk("idle_commit_per", counter_o, 3);
    chk("idle_commit_on", on_counter_o, 2);
    chk("idle_commit_kr", k_rise_o, 4);
    chk("idle_commit_kf", k_fall_o, 4);
    chk("idle_commit_ready", cfg_ready_o, 1);

    for (int i = 0; i < 17; i++) begin
      rst_i       = tbl[i].rst;
      start_i     = tbl[i].start;
      stop_i      = tbl[i].stop;
      prescaler_i = tbl[i].presc;
      step();
      chk($sformatf("v%0d_en", i), clk_en_o, tbl[i].en);
      chk($sformatf("v%0d_cr", i), cr_o, tbl[i].cr);
      chk($sformatf("v%0d_ps", i), period_start_o, tbl[i].ps);
      chk($sformatf("v%0d_busy", i), busy_o, tbl[i].busy);
      chk($sformatf("v%0d_done", i), done_o, tbl[i].done);
    end
    rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    chk("midrst_ready", cfg_ready_o, 1);
    chk("midrst_per", counter_o, 0);
    chk("midrst_amp", amplitude_o, 0);

    // Config update mid-period waits for the wrap.
    put_cfg(32'd3, 16'd8);
    step();
    prescaler_i = 16'd0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("mid_cr1", cr_o, 1);
    put_cfg(32'd3, 16'd5);
    chk("mid_ready_lo", cfg_ready_o, 0);
    chk("mid_amp_old", amplitude_o, 8);
    step();
    chk("mid_cr3", cr_o, 3);
    chk("mid_amp_old2", amplitude_o, 8);
    step();
    chk("wrap_cr0", cr_o, 0);
    chk("wrap_amp_new", amplitude_o, 5);
    chk("wrap_ready_hi", cfg_ready_o, 1);

    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else step();
    end
    chk("drain_done_seen", seen, 1);
    step();

    // Burst of two 2-tick periods.
    put_cfg(32'd1, 16'd8);
    step();
    chk("burst_per", counter_o, 1);
    burst_i = 8'd2;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    ticks = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (clk_en_o) ticks++;
      if (done_o) dones++;
      step();
    end
    chk("burst_ticks", ticks, 4);
    chk("burst_dones", dones, 1);
    chk("burst_busy", busy_o, 0);
    chk("burst_cr", cr_o, 0);

    // Zero-length period: every tick is a period start.
    put_cfg(32'd0, 16'd8);
    step();
    burst_i = 8'd3;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    ticks = 0; dones = 0; pss = 0;
    for (int i = 0; i < 8; i++) begin
      if (clk_en_o) ticks++;
      if (period_start_o) pss++;
      if (done_o) dones++;
      step();
    end
    chk("zero_ticks", ticks, 3);
    chk("zero_ps", pss, 3);
    chk("zero_dones", dones, 1);
    chk("zero_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
